// File: rtl/riscv_lsu_pkg.sv
// Shared definitions for the RISC-V load/store unit: funct3 size codes, FSM states
// and size normalisation. Optional feature macro: RISCV_LSU_MISALIGN_TRAP_EN (see riscv_lsu_bus).
package riscv_lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  // Codes 3, 6 and 7 have no encoding of their own and behave as word accesses.
  function automatic logic [2:0] norm_size(input logic [2:0] size);
    logic [2:0] res;
    case (size)
      LDST_B, LDST_H, LDST_BU, LDST_HU: res = size;
      default:                          res = LDST_W;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/riscv_lsu_lane.sv
// Combinational lane logic: byte enables and store replication for the bus width,
// plus load extraction with sign/zero extension.
module riscv_lsu_lane
  import riscv_lsu_pkg::*;
#(
  parameter int BUS_W = 32,
  parameter int OFF_W = $clog2(BUS_W / 8)
) (
  input  logic [OFF_W-1:0]   i_off,
  input  logic [2:0]         i_size,
  input  logic [31:0]        i_wd,
  input  logic [BUS_W-1:0]   i_rd,
  output logic [BUS_W/8-1:0] o_be,
  output logic [BUS_W-1:0]   o_wd,
  output logic [31:0]        o_rd
);

  localparam int BE_W = BUS_W / 8;

  logic [31:0] w_shift;

  assign w_shift = 32'(i_rd >> {i_off, 3'b000});

  // Select enables, replicated store data and extended load data by access size.
  always_comb begin
    o_be = {BE_W{1'b0}};
    o_wd = {BUS_W{1'b0}};
    o_rd = 32'h0;
    case (i_size)
      LDST_B: begin
        o_be = BE_W'(4'h1) << i_off;
        o_wd = {BE_W{i_wd[7:0]}};
        o_rd = {{24{w_shift[7]}}, w_shift[7:0]};
      end
      LDST_BU: begin
        o_be = BE_W'(4'h1) << i_off;
        o_wd = {BE_W{i_wd[7:0]}};
        o_rd = {24'h0, w_shift[7:0]};
      end
      LDST_H: begin
        o_be = BE_W'(4'h3) << i_off;
        o_wd = {(BUS_W / 16){i_wd[15:0]}};
        o_rd = {{16{w_shift[15]}}, w_shift[15:0]};
      end
      LDST_HU: begin
        o_be = BE_W'(4'h3) << i_off;
        o_wd = {(BUS_W / 16){i_wd[15:0]}};
        o_rd = {16'h0, w_shift[15:0]};
      end
      default: begin
        o_be = BE_W'(4'hF) << i_off;
        o_wd = {(BUS_W / 32){i_wd}};
        o_rd = w_shift;
      end
    endcase
  end

endmodule

// File: rtl/riscv_lsu_bus.sv
// Load/store unit bridging the single-cycle core to a variable-latency data memory.
// Define RISCV_LSU_MISALIGN_TRAP_EN to trap misaligned accesses (adds misalign_o).
module riscv_lsu_bus
  import riscv_lsu_pkg::*;
#(
  parameter int BUS_W          = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               core_req_i,
  input  logic               core_we_i,
  input  logic [2:0]         core_size_i,
  input  logic [31:0]        core_addr_i,
  input  logic [31:0]        core_wd_i,
  output logic [31:0]        core_rd_o,
  output logic               core_stall_o,
  output logic               bus_err_o,
  output logic               mem_req_o,
  output logic               mem_we_o,
  output logic [BUS_W/8-1:0] mem_be_o,
  output logic [31:0]        mem_addr_o,
  output logic [BUS_W-1:0]   mem_wd_o,
  input  logic [BUS_W-1:0]   mem_rd_i,
  input  logic               mem_ready_i
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
  ,
  output logic               misalign_o
`endif
);

  localparam int OFF_W = $clog2(BUS_W / 8);
  localparam int BE_W  = BUS_W / 8;
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  lsu_state_t       r_state, w_next;
  logic [OFF_W-1:0] r_off, w_raw_off, w_off, w_lane_off;
  logic [2:0]       r_size, w_size, w_lane_size;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mem_req, r_mem_we, r_err;
  logic [BE_W-1:0]  r_mem_be, w_be;
  logic [31:0]      r_mem_addr, r_rd, w_lane_rd;
  logic [BUS_W-1:0] r_mem_wd, w_wd;
  logic             w_trap, w_timeout, w_stall;

  assign w_size    = norm_size(core_size_i);
  assign w_raw_off = core_addr_i[OFF_W-1:0];
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

`ifdef RISCV_LSU_MISALIGN_TRAP_EN
  logic r_mis;
  assign w_trap = ((w_size == LDST_H) || (w_size == LDST_HU)) ? w_raw_off[0] :
                  ((w_size == LDST_W) ? (|w_raw_off[1:0]) : 1'b0);
  assign misalign_o = r_mis;
`else
  assign w_trap = 1'b0;
`endif

  // Misaligned offsets are forced down to the natural boundary of the access size.
  always_comb begin
    w_off = w_raw_off;
    case (w_size)
      LDST_H, LDST_HU: w_off[0]   = 1'b0;
      LDST_W:          w_off[1:0] = 2'b00;
      default:         w_off      = w_raw_off;
    endcase
  end

  // One lane instance: IDLE formats the incoming store, later states extract the load.
  assign w_lane_off  = (r_state == IDLE) ? w_off  : r_off;
  assign w_lane_size = (r_state == IDLE) ? w_size : r_size;

  riscv_lsu_lane #(
    .BUS_W (BUS_W)
  ) u_lane (
    .i_off  (w_lane_off),
    .i_size (w_lane_size),
    .i_wd   (core_wd_i),
    .i_rd   (mem_rd_i),
    .o_be   (w_be),
    .o_wd   (w_wd),
    .o_rd   (w_lane_rd)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and core stall.
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    case (r_state)
      IDLE: begin
        w_stall = core_req_i;
        if (core_req_i) begin
          w_next = w_trap ? DONE : BUSY;
        end else begin
          w_next = IDLE;
        end
      end
      BUSY: begin
        w_stall = 1'b1;
        if (mem_ready_i || w_timeout) begin
          w_next = DONE;
        end else begin
          w_next = BUSY;
        end
      end
      DONE: begin
        w_stall = 1'b0;
        w_next  = IDLE;
      end
      default: begin
        w_stall = core_req_i;
        w_next  = IDLE;
      end
    endcase
  end

  // Request capture, completion and timeout; ready wins over a coincident timeout.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_off      <= {OFF_W{1'b0}};
      r_size     <= 3'd0;
      r_cnt      <= {CNT_W{1'b0}};
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_mem_be   <= {BE_W{1'b0}};
      r_mem_addr <= 32'h0;
      r_mem_wd   <= {BUS_W{1'b0}};
      r_rd       <= 32'h0;
      r_err      <= 1'b0;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
      r_mis      <= 1'b0;
`endif
    end else begin
      r_err <= 1'b0;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
      r_mis <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (core_req_i && w_trap) begin
            r_rd <= 32'h0;
`ifdef RISCV_LSU_MISALIGN_TRAP_EN
            r_mis <= 1'b1;
`endif
          end else if (core_req_i) begin
            r_off      <= w_off;
            r_size     <= w_size;
            r_cnt      <= {CNT_W{1'b0}};
            r_mem_req  <= 1'b1;
            r_mem_we   <= core_we_i;
            r_mem_be   <= w_be;
            r_mem_addr <= {core_addr_i[31:OFF_W], {OFF_W{1'b0}}};
            r_mem_wd   <= w_wd;
          end
        end
        BUSY: begin
          if (mem_ready_i) begin
            r_rd      <= r_mem_we ? 32'h0 : w_lane_rd;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_mem_be  <= {BE_W{1'b0}};
          end else begin
            r_cnt <= r_cnt + CNT_W'(1'b1);
            if (w_timeout) begin
              r_err     <= 1'b1;
              r_rd      <= 32'h0;
              r_mem_req <= 1'b0;
              r_mem_we  <= 1'b0;
              r_mem_be  <= {BE_W{1'b0}};
            end
          end
        end
        default: begin
          r_err <= 1'b0;
        end
      endcase
    end
  end

  assign core_rd_o    = r_rd;
  assign core_stall_o = w_stall;
  assign bus_err_o    = r_err;
  assign mem_req_o    = r_mem_req;
  assign mem_we_o     = r_mem_we;
  assign mem_be_o     = r_mem_be;
  assign mem_addr_o   = r_mem_addr;
  assign mem_wd_o     = r_mem_wd;

endmodule

// File: doc/riscv_lsu_bus.md
Name: riscv_lsu_bus

Overview:
- Parametrised load/store unit between the single-cycle RISC-V core and a data memory with variable latency.
- Accepts one core access at a time. Formats byte enables and store lanes for a 32- or 64-bit bus, and extracts plus sign/zero-extends load data.
- Drives the core's stall_i.
- Adds a ready handshake, a bus-timeout error and wide-bus lane steering, none of which the core's direct memory port has.

Parameters:
- BUS_W, 32, memory data bus width; legal values 32 or 64.
- TIMEOUT_CYCLES, 16, cycles waited for mem_ready_i before a bus error is flagged; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- core_req_i  in  1  core requests a memory access (decoder mem_req)
- core_we_i  in  1  1 = store, 0 = load
- core_size_i  in  3  funct3 size code: 0 B, 1 H, 2 W, 4 BU, 5 HU
- core_addr_i  in  32  byte address (ALU result)
- core_wd_i  in  32  store data (RD2)
- core_rd_o  out  32  extended load data
- core_stall_o  out  1  stall to core
- bus_err_o  out  1  one-cycle pulse: access timed out
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write
- mem_be_o  out  BUS_W/8  byte enables
- mem_addr_o  out  32  bus-aligned address (low log2(BUS_W/8) bits zero)
- mem_wd_o  out  BUS_W  lane-steered write data
- mem_rd_i  in  BUS_W  read data, valid with mem_ready_i
- mem_ready_i  in  1  access complete

Behaviour:
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o, core_rd_o, bus_err_o and the timeout counter all go to 0.
  - core_stall_o = core_req_i, as in IDLE.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - core_stall_o = core_req_i (combinational).
  - On core_req_i, register the following and go to BUSY:
    - offset = addr[log2(BUS_W/8)-1:0];
    - size and we;
    - mem_addr_o = aligned address;
    - mem_be_o and mem_wd_o;
    - mem_req_o = 1.
- BUSY:
  - core_stall_o = 1; request outputs are held stable.
  - On mem_ready_i: register the extended load data into core_rd_o (stores write 0), clear mem_req_o/mem_we_o/mem_be_o, go to DONE.
  - Otherwise increment the counter. If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1:
    - pulse bus_err_o for 1 cycle;
    - set core_rd_o = 0;
    - drop the request and go to DONE.
  - mem_ready_i takes priority over timeout when both occur in the same cycle.
- DONE:
  - core_stall_o = 0 for exactly one cycle, so the core commits its write-back and PC.
  - core_req_i is ignored; the same instruction is still present.
  - Next state is IDLE.
- Latency: at least 3 cycles per access (IDLE, BUSY with ready, DONE); each extra wait cycle adds 1.
- Byte enables: B = 1 << offset; H = 3 << offset; W = 0xF << offset.
- Write data: the byte is replicated to every lane, the halfword to every 16-bit lane, the word to every 32-bit lane.
- Load extraction: mem_rd_i >> (8*offset), then sign-extend (B, H) or zero-extend (BU, HU); W is passed through.
- Misaligned accesses (H with offset[0] = 1; W with offset[1:0] != 0):
  - Without the macro, the low address bits are masked to the access size.
  - Size codes 3, 6 and 7 are treated as W.
- core_rd_o holds its value until the next completed access.

Optional Feature:
- Macro: RISCV_LSU_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port misalign_o (1 bit, reset 0).
  - A misaligned request in IDLE issues no memory request; the FSM goes straight to DONE with core_rd_o = 0.
  - misalign_o pulses for 1 cycle in DONE.
- Undefined: no port; misaligned addresses are masked as described in Behaviour.

Decomposition:
- Package riscv_lsu_pkg holds:
  - size localparams LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU;
  - enum lsu_state_t {IDLE, BUSY, DONE}.
- Sub-module riscv_lsu_lane: purely combinational, parametrised by BUS_W.
  - Inputs: offset, size, store data, read data.
  - Outputs: be, steered wd, extended rd.
- The FSM, timeout counter and registers stay in riscv_lsu_bus.

Test Plan:
- BUS_W=32, LW at addr 0x100, mem_ready_i on the first BUSY cycle, mem_rd_i=0xDEADBEEF: stall 1,1,0; core_rd_o=0xDEADBEEF; mem_addr_o=0x100; mem_be_o=0xF.
- BUS_W=32, SB addr 0x103, wd=0x000000A5: mem_be_o=0x8, mem_wd_o=0xA5A5A5A5, mem_we_o=1. Then LB/LBU at 0x103 with mem_rd_i=0x80000000 gives core_rd_o=0xFFFFFF80 and 0x00000080 respectively.
- BUS_W=64, LH at addr 0x206, mem_rd_i=0x8001_0000_0000_0000: mem_addr_o=0x200, mem_be_o=0xC0, core_rd_o=0xFFFF8001.
- TIMEOUT_CYCLES=4, mem_ready_i held 0: bus_err_o pulses once, mem_req_o drops after 4 BUSY cycles, core_rd_o=0, stall releases for 1 cycle.
- Assert rst_i asynchronously mid-BUSY, then reassert core_req_i: mem_req_o falls immediately without a clock edge; the next access completes normally.
- With RISCV_LSU_MISALIGN_TRAP_EN: LW at 0x102 gives mem_req_o never 1, misalign_o=1 in DONE, stall pattern 1,0. Without the macro: mem_addr_o=0x100, mem_be_o=0xF.
